// File: rtl/priv_1_12_trap_ctrl.sv
// Trap controller: picks one exception or interrupt at commit by priority,
// holds a flush request until the pipeline drains, then pulses intr.
module priv_1_12_trap_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        commit_valid,
    input  logic [31:0] epc_in,
    input  logic [31:0] insn_in,
    input  logic [31:0] badaddr_in,
    input  logic        ex_fault_insn,
    input  logic        ex_illegal,
    input  logic        ex_mal_insn,
    input  logic        ex_ecall,
    input  logic        ex_breakpoint,
    input  logic        ex_mal_s,
    input  logic        ex_mal_l,
    input  logic        ex_fault_s,
    input  logic        ex_fault_l,
    input  logic        msip,
    input  logic        mtip,
    input  logic        meip,
    input  logic        msie,
    input  logic        mtie,
    input  logic        meie,
    input  logic        mstatus_mie,
    input  logic [1:0]  curr_priv,
    input  logic        pipe_flush_done,
    output logic        flush_req,
    output logic        intr,
    output logic [31:0] next_mcause,
    output logic [31:0] next_mepc,
    output logic [31:0] next_mtval,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_TRAP  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_cap_cause;
    logic [31:0] r_cap_epc;
    logic [31:0] r_cap_tval;
    logic [31:0] r_mcause;
    logic [31:0] r_mepc;
    logic [31:0] r_mtval;

    logic        w_exc_any;
    logic [3:0]  w_exc_code;
    logic [31:0] w_exc_tval;
    logic        w_irq_any;
    logic [3:0]  w_irq_code;
    logic        w_u_mode;
    logic        w_capture;
    logic        w_commit_trap;

    assign w_u_mode = (curr_priv == 2'b00);

    assign w_exc_any = ex_fault_insn | ex_illegal | ex_mal_insn
                     | ex_ecall | ex_breakpoint | ex_mal_s
                     | ex_mal_l | ex_fault_s | ex_fault_l;

    always_comb begin
        w_exc_code = 4'd0;
        w_exc_tval = badaddr_in;
        if (ex_fault_insn) begin
            w_exc_code = 4'd1;
        end else if (ex_illegal) begin
            w_exc_code = 4'd2;
            w_exc_tval = insn_in;
        end else if (ex_mal_insn) begin
            w_exc_code = 4'd0;
        end else if (ex_ecall) begin
            w_exc_code = w_u_mode ? 4'd8 : 4'd11;
            w_exc_tval = 32'd0;
        end else if (ex_breakpoint) begin
            w_exc_code = 4'd3;
            w_exc_tval = epc_in;
        end else if (ex_mal_s) begin
            w_exc_code = 4'd6;
        end else if (ex_mal_l) begin
            w_exc_code = 4'd4;
        end else if (ex_fault_s) begin
            w_exc_code = 4'd7;
        end else if (ex_fault_l) begin
            w_exc_code = 4'd5;
        end
    end

    // Interrupts are always taken in U-mode; in M-mode only with MIE set.
    assign w_irq_any = ((meip & meie) | (msip & msie) | (mtip & mtie))
                     & (w_u_mode | mstatus_mie);

    always_comb begin
        w_irq_code = 4'd7;
        if (meip & meie) begin
            w_irq_code = 4'd11;
        end else if (msip & msie) begin
            w_irq_code = 4'd3;
        end
    end

    assign w_capture = (r_state == S_IDLE) & commit_valid
                     & (w_exc_any | w_irq_any);

    assign w_commit_trap = (r_state == S_DRAIN) & pipe_flush_done;

    always_comb begin
        w_next_state = r_state;
        flush_req    = 1'b0;
        intr         = 1'b0;
        busy         = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_capture) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                flush_req = 1'b1;
                if (pipe_flush_done) begin
                    w_next_state = S_TRAP;
                end
            end
            S_TRAP: begin
                intr         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cap_cause <= 32'd0;
            r_cap_epc   <= 32'd0;
            r_cap_tval  <= 32'd0;
        end else if (w_capture) begin
            r_cap_epc <= epc_in;
            if (w_exc_any) begin
                r_cap_cause <= {28'd0, w_exc_code};
                r_cap_tval  <= w_exc_tval;
            end else begin
                r_cap_cause <= {1'b1, 27'd0, w_irq_code};
                r_cap_tval  <= 32'd0;
            end
        end
    end

    // Outputs only move when a trap commits, so they hold between pulses.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_mcause <= 32'd0;
            r_mepc   <= 32'd0;
            r_mtval  <= 32'd0;
        end else if (w_commit_trap) begin
            r_mcause <= r_cap_cause;
            r_mepc   <= r_cap_epc;
            r_mtval  <= r_cap_tval;
        end
    end

    assign next_mcause = r_mcause;
    assign next_mepc   = r_mepc;
    assign next_mtval  = r_mtval;

endmodule

// File: tb/tb_priv_1_12_trap_ctrl.sv
// Bench for priv_1_12_trap_ctrl: directed cases plus random commits
// compared against a priority-table reference model.
module tb_priv_1_12_trap_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        commit_valid;
    logic [31:0] epc_in, insn_in, badaddr_in;
    logic        ex_fault_insn, ex_illegal, ex_mal_insn, ex_ecall;
    logic        ex_breakpoint, ex_mal_s, ex_mal_l, ex_fault_s;
    logic        ex_fault_l;
    logic        msip, mtip, meip, msie, mtie, meie, mstatus_mie;
    logic [1:0]  curr_priv;
    logic        pipe_flush_done;
    logic        flush_req, intr, busy;
    logic [31:0] next_mcause, next_mepc, next_mtval;

    int n_checks = 0;
    int n_err    = 0;

    always #5 CLK = ~CLK;

    priv_1_12_trap_ctrl dut (
        .CLK(CLK), .RST(RST),
        .commit_valid(commit_valid),
        .epc_in(epc_in), .insn_in(insn_in),
        .badaddr_in(badaddr_in),
        .ex_fault_insn(ex_fault_insn), .ex_illegal(ex_illegal),
        .ex_mal_insn(ex_mal_insn), .ex_ecall(ex_ecall),
        .ex_breakpoint(ex_breakpoint), .ex_mal_s(ex_mal_s),
        .ex_mal_l(ex_mal_l), .ex_fault_s(ex_fault_s),
        .ex_fault_l(ex_fault_l),
        .msip(msip), .mtip(mtip), .meip(meip),
        .msie(msie), .mtie(mtie), .meie(meie),
        .mstatus_mie(mstatus_mie), .curr_priv(curr_priv),
        .pipe_flush_done(pipe_flush_done),
        .flush_req(flush_req), .intr(intr),
        .next_mcause(next_mcause), .next_mepc(next_mepc),
        .next_mtval(next_mtval), .busy(busy)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        commit_valid  = 0;
        epc_in        = 0;
        insn_in       = 0;
        badaddr_in    = 0;
        ex_fault_insn = 0; ex_illegal = 0; ex_mal_insn = 0;
        ex_ecall      = 0; ex_breakpoint = 0; ex_mal_s = 0;
        ex_mal_l      = 0; ex_fault_s = 0; ex_fault_l = 0;
        msip = 0; mtip = 0; meip = 0;
        msie = 0; mtie = 0; meie = 0;
        mstatus_mie   = 0;
        curr_priv     = 2'b11;
    endtask

    task automatic scramble_inputs();
        commit_valid  = 1'($urandom);
        epc_in        = $urandom;
        insn_in       = $urandom;
        badaddr_in    = $urandom;
        ex_fault_insn = 1'($urandom); ex_illegal = 1'($urandom);
        ex_mal_insn   = 1'($urandom); ex_ecall = 1'($urandom);
        ex_breakpoint = 1'($urandom); ex_mal_s = 1'($urandom);
        ex_mal_l      = 1'($urandom); ex_fault_s = 1'($urandom);
        ex_fault_l    = 1'($urandom);
        {msip, mtip, meip} = 3'($urandom);
        {msie, mtie, meie} = 3'($urandom);
        mstatus_mie   = 1'($urandom);
        curr_priv     = 2'($urandom);
    endtask

    // Reference: walk the architectural priority tables in order.
    task automatic model(output bit v,
                         output logic [31:0] cause,
                         output logic [31:0] tval);
        bit          ex [9];
        int          code [9];
        logic [31:0] tv [9];
        bit          ip [3];
        int          icode [3];
        bit          u;
        u     = (curr_priv == 2'b00);
        ex    = '{ex_fault_insn, ex_illegal, ex_mal_insn, ex_ecall,
                  ex_breakpoint, ex_mal_s, ex_mal_l, ex_fault_s,
                  ex_fault_l};
        code  = '{1, 2, 0, u ? 8 : 11, 3, 6, 4, 7, 5};
        tv    = '{badaddr_in, insn_in, badaddr_in, 32'd0, epc_in,
                  badaddr_in, badaddr_in, badaddr_in, badaddr_in};
        ip    = '{meip & meie, msip & msie, mtip & mtie};
        icode = '{11, 3, 7};
        v     = 0;
        cause = 0;
        tval  = 0;
        if (!commit_valid) return;
        for (int i = 0; i < 9; i++) begin
            if (ex[i]) begin
                v     = 1;
                cause = code[i];
                tval  = tv[i];
                return;
            end
        end
        if (!(u || mstatus_mie)) return;
        for (int i = 0; i < 3; i++) begin
            if (ip[i]) begin
                v     = 1;
                cause = 32'h8000_0000 | icode[i];
                return;
            end
        end
    endtask

    // Inputs for cycle 0 must be set by the caller before calling run.
    task automatic run(input string tag, input int stall);
        bit          v;
        logic [31:0] c, t, e;
        int          nflush;
        model(v, c, t);
        e = epc_in;
        pipe_flush_done = 1'($urandom);
        step();
        if (!v) begin
            check({tag, ":idle_busy"}, 32'(busy), 0);
            check({tag, ":idle_flush"}, 32'(flush_req), 0);
            clear_inputs();
            pipe_flush_done = 0;
            step();
            return;
        end
        nflush = 0;
        for (int cyc = 1; cyc <= stall + 1; cyc++) begin
            check({tag, ":drain_intr"}, 32'(intr), 0);
            check({tag, ":drain_busy"}, 32'(busy), 1);
            if (flush_req === 1'b1) nflush++;
            scramble_inputs();
            pipe_flush_done = (cyc > stall);
            step();
        end
        check({tag, ":nflush"}, 32'(nflush), 32'(stall + 1));
        check({tag, ":intr"}, 32'(intr), 1);
        check({tag, ":trap_flush"}, 32'(flush_req), 0);
        check({tag, ":mcause"}, next_mcause, c);
        check({tag, ":mepc"}, next_mepc, e);
        check({tag, ":mtval"}, next_mtval, t);
        clear_inputs();
        pipe_flush_done = 1'($urandom);
        step();
        check({tag, ":post_intr"}, 32'(intr), 0);
        check({tag, ":post_busy"}, 32'(busy), 0);
        check({tag, ":hold"}, next_mcause, c);
    endtask

    initial begin
        clear_inputs();
        pipe_flush_done = 0;
        RST = 1;
        step();
        check("rst_flush", 32'(flush_req), 0);
        check("rst_intr", 32'(intr), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_mcause", next_mcause, 0);
        check("rst_mepc", next_mepc, 0);
        check("rst_mtval", next_mtval, 0);
        RST = 0;
        step();

        // Illegal instruction in M-mode
        clear_inputs();
        commit_valid = 1; ex_illegal = 1;
        insn_in = 32'hFFFF_FFFF; epc_in = 32'h100;
        run("illegal", 0);

        // ecall beats mal_l and MEI; cause depends on privilege
        clear_inputs();
        commit_valid = 1; ex_ecall = 1; ex_mal_l = 1;
        meip = 1; meie = 1; curr_priv = 2'b00;
        epc_in = 32'h200; badaddr_in = 32'hDEAD;
        run("ecall_u", 0);
        clear_inputs();
        commit_valid = 1; ex_ecall = 1; ex_mal_l = 1;
        meip = 1; meie = 1; curr_priv = 2'b11;
        epc_in = 32'h204; badaddr_in = 32'hBEEF;
        run("ecall_m", 1);

        // Timer interrupt masked in M, taken in U
        clear_inputs();
        commit_valid = 1; mtip = 1; mtie = 1;
        curr_priv = 2'b11; epc_in = 32'h300;
        run("mti_mask", 0);
        clear_inputs();
        commit_valid = 1; mtip = 1; mtie = 1;
        curr_priv = 2'b00; epc_in = 32'h304;
        run("mti_u", 0);

        // Long drain with garbage inputs during DRAIN
        clear_inputs();
        commit_valid = 1; ex_fault_l = 1;
        epc_in = 32'h400; badaddr_in = 32'h1234_5678;
        run("stall5", 5);

        clear_inputs();
        commit_valid = 1; ex_breakpoint = 1; epc_in = 32'h2000;
        run("bkpt", 0);

        // Reset in the second DRAIN cycle aborts the trap
        clear_inputs();
        commit_valid = 1; ex_illegal = 1;
        epc_in = 32'h500; insn_in = 32'hABCD;
        pipe_flush_done = 0;
        step();
        clear_inputs();
        step();
        check("rst_mid_flush_pre", 32'(flush_req), 1);
        RST = 1;
        #1;
        check("rst_mid_flush", 32'(flush_req), 0);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_intr", 32'(intr), 0);
        check("rst_mid_mcause", next_mcause, 0);
        check("rst_mid_mepc", next_mepc, 0);
        check("rst_mid_mtval", next_mtval, 0);
        pipe_flush_done = 1;
        step();
        RST = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rst_no_intr", 32'(intr), 0);
        end
        clear_inputs();
        commit_valid = 1; ex_mal_s = 1;
        epc_in = 32'h600; badaddr_in = 32'h601;
        run("after_rst", 2);

        // Random commits
        for (int n = 0; n < 60; n++) begin
            clear_inputs();
            commit_valid  = ($urandom_range(0, 3) != 0);
            epc_in        = $urandom;
            insn_in       = $urandom;
            badaddr_in    = $urandom;
            ex_fault_insn = ($urandom_range(0, 15) == 0);
            ex_illegal    = ($urandom_range(0, 15) == 0);
            ex_mal_insn   = ($urandom_range(0, 15) == 0);
            ex_ecall      = ($urandom_range(0, 15) == 0);
            ex_breakpoint = ($urandom_range(0, 15) == 0);
            ex_mal_s      = ($urandom_range(0, 15) == 0);
            ex_mal_l      = ($urandom_range(0, 15) == 0);
            ex_fault_s    = ($urandom_range(0, 15) == 0);
            ex_fault_l    = ($urandom_range(0, 15) == 0);
            {msip, mtip, meip} = 3'($urandom);
            {msie, mtie, meie} = 3'($urandom);
            mstatus_mie   = 1'($urandom);
            curr_priv     = 2'($urandom);
            run("rand", $urandom_range(0, 4));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
